// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-port to valid/ready stream adapter.
// Output buffer depth is one word more than the FIFO read latency so a full pipe never stalls.
package fifo_rd_pkg;

    localparam int RD_LAT_NOREG = 1;
    localparam int RD_LAT_OREG  = 2;
    localparam int LVL_W        = 2;

    typedef logic [LVL_W-1:0] buf_lvl_t;

    function automatic int buf_depth(input int rd_latency);
        return (rd_latency == RD_LAT_OREG) ? RD_LAT_OREG + 1 : RD_LAT_NOREG + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small register FIFO holding words returned by the read port; entry 0 is always the oldest.
// Zero-latency pop, one-cycle push-to-visible; clear dominates push/pop and resets the level.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_dat,
    input  logic                  i_pop,
    input  logic                  i_clear,
    output logic [DATA_WIDTH-1:0] o_dat,
    output buf_lvl_t              o_level
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    buf_lvl_t              r_level;
    logic [DATA_WIDTH-1:0] w_mem_nxt [DEPTH];
    buf_lvl_t              w_wr_idx;
    buf_lvl_t              w_level_nxt;

    // A push alongside a pop lands one slot lower, since everything shifts down.
    assign w_wr_idx    = r_level - buf_lvl_t'(i_pop);
    assign w_level_nxt = r_level + buf_lvl_t'(i_push) - buf_lvl_t'(i_pop);

    always_comb begin
        w_mem_nxt = r_mem;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (i_pop) begin
                w_mem_nxt[i] = r_mem[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i_push && (buf_lvl_t'(i) == w_wr_idx)) begin
                w_mem_nxt[i] = i_push_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_level <= '0;
        end else if (i_clear) begin
            r_level <= '0;
        end else begin
            r_mem   <= w_mem_nxt;
            r_level <= w_level_nxt;
        end
    end

    assign o_dat   = r_mem[0];
    assign o_level = r_level;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_pop && !i_clear && (r_level == buf_lvl_t'(DEPTH))));

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns a standard-mode FIFO read port into a valid/ready stream; RD_LATENCY+1 cycles rd_en to m_valid.
// Reads are issued only when buffer space is guaranteed for every in-flight word, so m_ready may drop at any time.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    output logic                  rd_en,
    input  logic                  rd_empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_oce,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            buf_level,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    localparam int BUF_DEPTH = buf_depth(RD_LATENCY);

    logic [1:0]            r_rst_sync;
    logic [RD_LATENCY-1:0] r_infl;
    logic [CNT_WIDTH-1:0]  r_beat_cnt;

    logic [RD_LATENCY-1:0] w_infl_nxt;
    logic [2:0]            w_infl_cnt;
    logic [2:0]            w_occ;
    logic                  w_pop;
    logic                  w_land;
    buf_lvl_t              w_level;

    // Reset release is retimed so the first read cannot race the deassertion edge.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_pop      = m_valid & m_ready;
    assign w_land     = r_infl[RD_LATENCY-1];
    assign w_infl_cnt = 3'($countones(r_infl));
    assign w_occ      = {1'b0, w_level} + w_infl_cnt - {2'b00, w_pop};

    assign rd_en  = r_rst_sync[1] & ~rd_empty & ~flush & (w_occ < 3'(BUF_DEPTH));
    assign rd_oce = 1'b1;

    generate
        if (RD_LATENCY > 1) begin : g_shift
            assign w_infl_nxt = {r_infl[RD_LATENCY-2:0], rd_en};
        end else begin : g_single
            assign w_infl_nxt = rd_en;
        end
    endgenerate

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_infl <= '0;
        end else if (flush) begin
            r_infl <= '0;
        end else begin
            r_infl <= w_infl_nxt;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_skid_buf (
        .clk        (rd_clk),
        .rst_n      (rd_rst_n),
        .i_push     (w_land),
        .i_push_dat (rd_data),
        .i_pop      (w_pop),
        .i_clear    (flush),
        .o_dat      (m_data),
        .o_level    (w_level)
    );

    assign m_valid   = (w_level != '0);
    assign buf_level = w_level;
    assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Two adapters (read latency 1 with a 16-bit counter, latency 2 with a 4-bit counter) fed from FIFO models.
// Loaded words go into a per-instance scoreboard; every stream handshake pops and compares.
module tb_fifo_rd_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        m_ready;
    logic [1:0]  rd_en_v;
    logic [1:0]  oce_v;
    logic [1:0]  mv_v;
    logic [1:0]  empty_v;
    logic [7:0]  mdat [2];
    logic [1:0]  lvl [2];
    logic [15:0] bc0;
    logic [3:0]  bc1;

    logic [7:0] fmem [2][256];
    int         rp [2];
    int         wp [2];
    logic [7:0] dq1 [2];
    logic [7:0] dq2 [2];

    logic [7:0] exp_mem [2][256];
    int         exp_rd [2];
    int         exp_wr [2];

    int         beats [2];
    int         rden_cnt [2];
    int         first_rden [2];
    int         first_mv [2];
    int         last_rden [2];
    int         max_lvl [2];
    bit         prev_hold [2];
    logic [7:0] prev_dat [2];
    int         cyc;
    int         total;
    int         bad;
    int         pend0;
    int         pend1;

    assign empty_v[0] = (rp[0] == wp[0]);
    assign empty_v[1] = (rp[1] == wp[1]);

    fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(1), .CNT_WIDTH(16)) u_dut_l1 (
        .rd_clk(clk), .rd_rst_n(rst_n), .rd_en(rd_en_v[0]), .rd_empty(empty_v[0]),
        .rd_data(dq1[0]), .rd_oce(oce_v[0]), .flush(flush), .m_valid(mv_v[0]),
        .m_ready(m_ready), .m_data(mdat[0]), .buf_level(lvl[0]), .beat_cnt(bc0)
    );

    fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(2), .CNT_WIDTH(4)) u_dut_l2 (
        .rd_clk(clk), .rd_rst_n(rst_n), .rd_en(rd_en_v[1]), .rd_empty(empty_v[1]),
        .rd_data(dq2[1]), .rd_oce(oce_v[1]), .flush(flush), .m_valid(mv_v[1]),
        .m_ready(m_ready), .m_data(mdat[1]), .buf_level(lvl[1]), .beat_cnt(bc1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Standard-mode FIFO: data one cycle after rd_en; the latency-2 port adds an always-enabled output register.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (rd_en_v[k] && (rp[k] != wp[k])) begin
                dq1[k] <= fmem[k][rp[k]];
                rp[k]  <= rp[k] + 1;
            end
            dq2[k] <= dq1[k];
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                exp_rd[k]    = exp_wr[k] - (wp[k] - rp[k]);
                beats[k]     = 0;
                prev_hold[k] = 1'b0;
            end else begin
                if (rd_en_v[k]) begin
                    rden_cnt[k]++;
                    last_rden[k] = cyc;
                    if (first_rden[k] < 0) first_rden[k] = cyc;
                    check_val($sformatf("rden_when_empty%0d", k), 32'(empty_v[k]), 32'd0);
                end
                if (mv_v[k] && first_mv[k] < 0) first_mv[k] = cyc;
                check_val($sformatf("mvalid_vs_level%0d", k), 32'(mv_v[k]), 32'(lvl[k] != 2'd0));
                if (prev_hold[k] && mv_v[k])
                    check_val($sformatf("hold_data%0d", k), 32'(mdat[k]), 32'(prev_dat[k]));
                if (int'(lvl[k]) > max_lvl[k]) max_lvl[k] = int'(lvl[k]);
                if (mv_v[k] && m_ready) begin
                    if (exp_rd[k] < exp_wr[k]) begin
                        check_val($sformatf("beat%0d", k), 32'(mdat[k]), 32'(exp_mem[k][exp_rd[k]]));
                        exp_rd[k]++;
                    end else begin
                        check_val($sformatf("unexpected_beat%0d", k), 32'(mdat[k]), 32'hDEAD_BEEF);
                    end
                    beats[k]++;
                end
                prev_hold[k] = mv_v[k] && !m_ready;
                prev_dat[k]  = mdat[k];
                // Flush drops every word already taken from the FIFO but not yet handed out.
                if (flush) exp_rd[k] = exp_wr[k] - (wp[k] - rp[k]);
            end
        end
    end

    task automatic load(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 2; k++) begin
                fmem[k][wp[k]]        = base + 8'(i);
                wp[k]                 = wp[k] + 1;
                exp_mem[k][exp_wr[k]] = base + 8'(i);
                exp_wr[k]             = exp_wr[k] + 1;
            end
        end
    endtask

    task automatic wait_drain(input int budget, input bit toggle);
        int n = 0;
        while ((exp_rd[0] != exp_wr[0] || exp_rd[1] != exp_wr[1]) && n < budget) begin
            @(posedge clk);
            #1;
            if (toggle) m_ready = ~m_ready;
            n++;
        end
        m_ready = 1'b1;
        check_val("drain0_left", 32'(exp_wr[0] - exp_rd[0]), 32'd0);
        check_val("drain1_left", 32'(exp_wr[1] - exp_rd[1]), 32'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_rd_en"}, 32'(rd_en_v), 32'd0);
        check_val({tag, "_m_valid"}, 32'(mv_v), 32'd0);
        check_val({tag, "_m_data0"}, 32'(mdat[0]), 32'd0);
        check_val({tag, "_m_data1"}, 32'(mdat[1]), 32'd0);
        check_val({tag, "_level0"}, 32'(lvl[0]), 32'd0);
        check_val({tag, "_level1"}, 32'(lvl[1]), 32'd0);
        check_val({tag, "_beat0"}, 32'(bc0), 32'd0);
        check_val({tag, "_beat1"}, 32'(bc1), 32'd0);
        check_val({tag, "_rd_oce"}, 32'(oce_v), 32'd3);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rel_rden_cyc1", 32'(rd_en_v), 32'd0);
        @(negedge clk);
        check_val("rel_rden_cyc2", 32'(rd_en_v), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        cyc     = 0;
        total   = 0;
        bad     = 0;
        for (int k = 0; k < 2; k++) begin
            first_rden[k] = -1;
            first_mv[k]   = -1;
            dq1[k]        = '0;
            dq2[k]        = '0;
        end
        #2 check_reset_outs("por");

        // 16-word burst at full rate
        load(8'h01, 16);
        repeat (3) @(posedge clk);
        release_rst();
        wait_drain(100, 1'b0);
        check_val("latency_l1", 32'(first_mv[0] - first_rden[0]), 32'd2);
        check_val("latency_l2", 32'(first_mv[1] - first_rden[1]), 32'd3);
        check_val("reads_l1", 32'(rden_cnt[0]), 32'd16);
        check_val("reads_l2", 32'(rden_cnt[1]), 32'd16);
        check_val("read_span_l1", 32'(last_rden[0] - first_rden[0]), 32'd15);
        check_val("read_span_l2", 32'(last_rden[1] - first_rden[1]), 32'd15);
        check_val("beat_cnt_16_l1", 32'(bc0), 32'd16);
        check_val("beat_cnt_16_l2", 32'(bc1), 32'd0);

        // 17th beat wraps the 4-bit counter to 1
        load(8'h11, 1);
        wait_drain(20, 1'b0);
        check_val("beat_cnt_17_l1", 32'(bc0), 32'd17);
        check_val("beat_cnt_wrap_l2", 32'(bc1), 32'd1);

        // sink ready toggling every cycle
        load(8'h81, 16);
        m_ready = 1'b0;
        wait_drain(200, 1'b1);
        check_val("beat_cnt_33_l1", 32'(bc0), 32'd33);
        check_val("beat_cnt_33_l2", 32'(bc1), 32'd1);

        // long stall: reads stop once the buffer plus pipe is full
        m_ready     = 1'b0;
        rden_cnt[0] = 0;
        rden_cnt[1] = 0;
        load(8'h21, 8);
        repeat (20) @(posedge clk);
        #1;
        check_val("stall_reads_l1", 32'(rden_cnt[0]), 32'd2);
        check_val("stall_reads_l2", 32'(rden_cnt[1]), 32'd3);
        check_val("stall_data_l1", 32'(mdat[0]), 32'h21);
        check_val("stall_data_l2", 32'(mdat[1]), 32'h21);
        check_val("stall_level_l1", 32'(lvl[0]), 32'd2);
        check_val("stall_level_l2", 32'(lvl[1]), 32'd3);
        m_ready = 1'b1;
        wait_drain(100, 1'b0);
        check_val("beat_cnt_41_l1", 32'(bc0), 32'd41);
        check_val("beat_cnt_41_l2", 32'(bc1), 32'd9);

        // flush with two words buffered and one still in flight (latency-2 instance)
        m_ready = 1'b0;
        load(8'h31, 8);
        begin
            int n = 0;
            while (lvl[1] != 2'd2 && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check_val("preflush_level_l2", 32'(lvl[1]), 32'd2);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check_val("flush_level_l1", 32'(lvl[0]), 32'd0);
        check_val("flush_level_l2", 32'(lvl[1]), 32'd0);
        @(negedge clk);
        check_val("flush_inflight_dropped_l2", 32'(lvl[1]), 32'd0);
        @(posedge clk);
        #1 m_ready = 1'b1;
        wait_drain(100, 1'b0);
        check_val("beat_cnt_flush_l1", 32'(bc0), 32'd47);
        check_val("beat_cnt_flush_l2", 32'(bc1), 32'd14);

        // reset in the middle of a burst
        load(8'h41, 16);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outs("midrst");
        pend0 = wp[0] - rp[0];
        pend1 = wp[1] - rp[1];
        repeat (2) @(posedge clk);
        release_rst();
        wait_drain(100, 1'b0);
        check_val("beat_cnt_after_rst_l1", 32'(bc0), 32'(pend0));
        check_val("beat_cnt_after_rst_l2", 32'(bc1), 32'(pend1 % 16));

        check_val("max_level_l1", 32'(max_lvl[0]), 32'd2);
        check_val("max_level_l2", 32'(max_lvl[1]), 32'd3);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
